dna_crossover_engine: RTL and testbench

- Parametrised genetic crossover engine for the FPGA ANN trainer.
- Triggered after fitness ranking. Reads the ELITE_COUNT surviving genomes from genome RAM and breeds every unordered elite pair gene-by-gene with uniform crossover and per-gene mutation.
- Writes offspring into slots ELITE_COUNT..POPULATION-1.
- Owns the RAM port only while busy; an external arbiter muxes the port by busy.

---
 rtl/dna_crossover_engine.sv | 199 +++++++++++++++++++
 tb/tb_dna_crossover_engine.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dna_crossover_engine.sv
// Genetic crossover engine: breeds every unordered pair of elite genomes gene-by-gene
// into the offspring slots, using uniform crossover with per-gene mutation.
//
// state | meaning
// IDLE  | waiting for start, RAM port not owned
// RD_A  | reading parent A's gene
// RD_B  | reading parent B's gene
// WR    | writing the offspring gene
// NEXT  | advancing gene/slot/pair counters
// DONE  | one-cycle completion pulse
module dna_crossover_engine #(
  parameter int GENE_WIDTH      = 16,
  parameter int GENOME_LEN      = 5,
  parameter int ELITE_COUNT     = 4,
  parameter int POPULATION      = 16,
  parameter int ADDR_WIDTH      = 23,
  parameter int LOW_MUT_THRESH  = 5,
  parameter int HIGH_MUT_THRESH = 51,
  parameter int GENE_RANGE      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [23:0]           rand_in,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [GENE_WIDTH-1:0] mem_wdata,
  input  logic [GENE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [15:0]           mutation_count
);

  localparam int SW = $clog2(POPULATION + 1);
  localparam int GW = $clog2(GENOME_LEN + 1);

  generate
    if (ELITE_COUNT < 2 || POPULATION <= ELITE_COUNT || GENOME_LEN < 1 ||
        GENE_RANGE < 1 || GENE_RANGE > 256 ||
        LOW_MUT_THRESH > 255 || HIGH_MUT_THRESH > 255) begin : gParamCheck
      $error("dna_crossover_engine: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR, NEXT, DONE} stateT;

  stateT                 state;
  logic [GW-1:0]         geneIdx;
  logic [SW-1:0]         slotIdx;
  logic [SW-1:0]         parA;
  logic [SW-1:0]         parB;
  logic                  pass;
  logic [GENE_WIDTH-1:0] geneA;

  logic                  lastGene;
  logic                  lastSlot;
  logic [GW-1:0]         nGene;
  logic [SW-1:0]         nSlot;
  logic [SW-1:0]         nA;
  logic [SW-1:0]         nB;
  logic                  nPass;
  logic [7:0]            thresh;
  logic                  mutate;
  logic [8:0]            mutVal;
  logic [GENE_WIDTH-1:0] wdataNext;
  logic                  unusedRand;

  function automatic logic [ADDR_WIDTH-1:0] addrOf(input logic [SW-1:0] slot,
                                                   input logic [GW-1:0] gene);
    return ADDR_WIDTH'(slot) * ADDR_WIDTH'(GENOME_LEN) + ADDR_WIDTH'(gene);
  endfunction

  // The pair list wraps to (0,1) once exhausted; pass only distinguishes first vs later.
  always_comb begin
    lastGene = (geneIdx == GW'(GENOME_LEN - 1));
    lastSlot = (slotIdx == SW'(POPULATION - 1));
    nGene    = lastGene ? '0 : geneIdx + 1'b1;
    nSlot    = lastGene ? slotIdx + 1'b1 : slotIdx;
    nA       = parA;
    nB       = parB;
    nPass    = pass;
    if (lastGene) begin
      if (parB == SW'(ELITE_COUNT - 1)) begin
        if (parA == SW'(ELITE_COUNT - 2)) begin
          nA    = '0;
          nB    = SW'(1);
          nPass = 1'b1;
        end else begin
          nA = parA + 1'b1;
          nB = parA + SW'(2);
        end
      end else begin
        nB = parB + 1'b1;
      end
    end
  end

  // Parent B's gene is only valid during the RD_B ack, so the write data is chosen there.
  always_comb begin
    thresh    = pass ? 8'(HIGH_MUT_THRESH) : 8'(LOW_MUT_THRESH);
    mutate    = (rand_in[7:0] < thresh);
    mutVal    = {1'b0, rand_in[23:16]} % 9'(GENE_RANGE);
    wdataNext = mutate ? GENE_WIDTH'(mutVal) : (rand_in[8] ? mem_rdata : geneA);
  end

  assign unusedRand = ^rand_in[15:9];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mutation_count <= '0;
      geneIdx        <= '0;
      slotIdx        <= '0;
      parA           <= '0;
      parB           <= '0;
      pass           <= 1'b0;
      geneA          <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        busy    <= 1'b0;
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state          <= RD_A;
              busy           <= 1'b1;
              mutation_count <= '0;
              geneIdx        <= '0;
              slotIdx        <= SW'(ELITE_COUNT);
              parA           <= '0;
              parB           <= SW'(1);
              pass           <= 1'b0;
              mem_req        <= 1'b1;
              mem_we         <= 1'b0;
              mem_addr       <= '0;
            end
          end
          RD_A: begin
            if (mem_ack) begin
              geneA    <= mem_rdata;
              mem_addr <= addrOf(parB, geneIdx);
              state    <= RD_B;
            end
          end
          RD_B: begin
            if (mem_ack) begin
              mem_we    <= 1'b1;
              mem_addr  <= addrOf(slotIdx, geneIdx);
              mem_wdata <= wdataNext;
              if (mutate && mutation_count != 16'hFFFF)
                mutation_count <= mutation_count + 16'd1;
              state <= WR;
            end
          end
          WR: begin
            if (mem_ack) begin
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              state   <= NEXT;
            end
          end
          NEXT: begin
            geneIdx <= nGene;
            slotIdx <= nSlot;
            parA    <= nA;
            parB    <= nB;
            pass    <= nPass;
            if (lastGene && lastSlot) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= RD_A;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= addrOf(nA, nGene);
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dna_crossover_engine.sv
// Scoreboarded bench for dna_crossover_engine: a loop-based model predicts every RAM
// access of a generation; a monitor checks each completed access against it.
module tb_dna_crossover_engine;
  localparam int GL    = 5;
  localparam int EC    = 4;
  localparam int POP   = 16;
  localparam int AW    = 23;
  localparam int GWD   = 16;
  localparam int LOWT  = 5;
  localparam int HIGHT = 51;
  localparam int GR    = 4;
  localparam int WORDS = POP * GL;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           abort;
  logic [23:0]    rand_in;
  logic           busy;
  logic           done;
  logic           mem_req;
  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [GWD-1:0] mem_wdata;
  logic [GWD-1:0] mem_rdata;
  logic           mem_ack;
  logic [15:0]    mutation_count;

  always #5 clk = ~clk;

  dna_crossover_engine #(
    .GENE_WIDTH(GWD), .GENOME_LEN(GL), .ELITE_COUNT(EC), .POPULATION(POP),
    .ADDR_WIDTH(AW), .LOW_MUT_THRESH(LOWT), .HIGH_MUT_THRESH(HIGHT), .GENE_RANGE(GR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .rand_in(rand_in),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mutation_count(mutation_count)
  );

  typedef struct packed {
    logic           we;
    logic [AW-1:0]  addr;
    logic [GWD-1:0] data;
  } accT;

  accT            expQ[$];
  logic [GWD-1:0] ram[WORDS];
  logic [GWD-1:0] expRam[WORDS];
  int             vectors = 0;
  int             miscompares = 0;
  bit             ackHold = 1'b0;
  bit             randDelay = 1'b0;
  bit             pending = 1'b0;
  int             waitCnt = 0;
  bit             justDone = 1'b0;
  logic           prevReq = 1'b0;
  logic           prevWe = 1'b0;
  logic [AW-1:0]  prevAddr = '0;
  logic [GWD-1:0] prevData = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic accT mk(input logic we, input int addr, input logic [GWD-1:0] data);
    accT a;
    a.we   = we;
    a.addr = AW'(addr);
    a.data = data;
    return a;
  endfunction

  // RAM model: each request is acknowledged after 0..7 extra cycles (or none while held).
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req && !ackHold) begin
      if (!pending) begin
        pending = 1'b1;
        waitCnt = randDelay ? int'($urandom_range(0, 7)) : 0;
      end
      if (waitCnt == 0) begin
        mem_ack = 1'b1;
        pending = 1'b0;
        if (int'(mem_addr) < WORDS) begin
          if (mem_we) ram[int'(mem_addr)] = mem_wdata;
          else mem_rdata = ram[int'(mem_addr)];
        end
      end else begin
        waitCnt--;
      end
    end else if (!mem_req) begin
      pending = 1'b0;
    end
  end

  always @(posedge clk) begin
    accT e;
    justDone = 1'b0;
    if (!rst && mem_req && mem_ack) begin
      justDone = 1'b1;
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("FAIL access: got unexpected we=%0b addr=%0d data=%0h, expected none",
                 mem_we, mem_addr, mem_wdata);
      end else begin
        e = expQ.pop_front();
        if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.data)) begin
          miscompares++;
          $display("FAIL access: got we=%0b addr=%0d data=%0h, expected we=%0b addr=%0d data=%0h",
                   mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mem_req && prevReq && !justDone) begin
      vectors++;
      if (mem_we !== prevWe || mem_addr !== prevAddr || mem_wdata !== prevData) begin
        miscompares++;
        $display("FAIL stable: got we=%0b addr=%0d data=%0h, expected we=%0b addr=%0d data=%0h",
                 mem_we, mem_addr, mem_wdata, prevWe, prevAddr, prevData);
      end
    end
    prevReq  = mem_req;
    prevWe   = mem_we;
    prevAddr = mem_addr;
    prevData = mem_wdata;
  end

  // Reference: enumerate pairs, assign them to offspring slots in order, decide each gene.
  task automatic pushGeneration(input logic [23:0] r, output int mut);
    int pa[$];
    int pb[$];
    int k, a, b, th;
    logic [GWD-1:0] d;
    mut = 0;
    for (int i = 0; i < EC; i++)
      for (int j = i + 1; j < EC; j++) begin
        pa.push_back(i);
        pb.push_back(j);
      end
    for (int s = EC; s < POP; s++) begin
      k  = s - EC;
      a  = pa[k % pa.size()];
      b  = pb[k % pb.size()];
      th = (k >= pa.size()) ? HIGHT : LOWT;
      for (int g = 0; g < GL; g++) begin
        expQ.push_back(mk(1'b0, a * GL + g, '0));
        expQ.push_back(mk(1'b0, b * GL + g, '0));
        if (int'(r[7:0]) < th) begin
          d = GWD'(int'(r[23:16]) % GR);
          mut++;
        end else begin
          d = r[8] ? expRam[b * GL + g] : expRam[a * GL + g];
        end
        expRam[s * GL + g] = d;
        expQ.push_back(mk(1'b1, s * GL + g, d));
      end
    end
    if (mut > 65535) mut = 65535;
  endtask

  task automatic runGen(input logic [23:0] r, input bit rnd, input int againAt);
    int expMut, n, bad;
    rand_in   = r;
    randDelay = rnd;
    pushGeneration(r, expMut);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
    check("mutcount_cleared", 64'(mutation_count), 64'(0));
    n = 1;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
      start = (againAt > 0 && n == againAt);
    end
    start = 1'b0;
    check("done_seen", 64'(done), 64'(1));
    if (!rnd) check("done_cycle", 64'(n + 1), 64'(1 + 4 * GL * (POP - EC) + 1));
    check("busy_at_done", 64'(busy), 64'(0));
    check("mutation_count", 64'(mutation_count), 64'(expMut));
    check("queue_drained", 64'(expQ.size()), 64'(0));
    bad = 0;
    for (int i = 0; i < WORDS; i++) if (ram[i] !== expRam[i]) bad++;
    check("ram_image_bad_words", 64'(bad), 64'(0));
    @(negedge clk);
    check("done_pulse_width", 64'(done), 64'(0));
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_req"}, 64'(mem_req), 64'(0));
    check({tag, "_we"}, 64'(mem_we), 64'(0));
    check({tag, "_addr"}, 64'(mem_addr), 64'(0));
    check({tag, "_wdata"}, 64'(mem_wdata), 64'(0));
    check({tag, "_mutcnt"}, 64'(mutation_count), 64'(0));
  endtask

  task automatic waitAccess(input logic we, input int addr, output bit found);
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (mem_req && mem_we == we && int'(mem_addr) == addr) found = 1'b1;
    end
    check("access_reached", 64'(found), 64'(1));
  endtask

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog: got time limit expiry, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found, sawDone;
    rst = 1'b1; start = 1'b0; abort = 1'b0; rand_in = '0; mem_rdata = '0; mem_ack = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      ram[i]    = GWD'($urandom);
      expRam[i] = ram[i];
    end
    #12;
    checkReset("reset");
    @(negedge clk);
    rst = 1'b0;

    runGen(24'h0000FF, 1'b0, 0);
    runGen(24'h070000, 1'b0, 0);
    runGen(24'h000014, 1'b0, 0);
    runGen(24'h000100, 1'b0, 0);
    for (int t = 0; t < 3; t++) runGen(24'($urandom), 1'b1, (t == 1) ? 37 : 0);

    // start and abort together: nothing starts
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("startabort_busy", 64'(busy), 64'(0));
    check("startabort_req", 64'(mem_req), 64'(0));

    // abort during the write of slot 6 gene 2
    rand_in = 24'h000000;
    randDelay = 1'b0;
    begin
      int m;
      pushGeneration(rand_in, m);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitAccess(1'b1, 6 * GL + 2, found);
    ackHold = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_req", 64'(mem_req), 64'(0));
    check("abort_mutcnt_held", 64'(mutation_count), 64'(2 * GL + 3));
    expQ.delete();
    ackHold = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    check("abort_no_done", 64'(sawDone), 64'(0));
    runGen(24'h000000, 1'b0, 0);

    // asynchronous reset in the middle of RD_B
    rand_in = 24'($urandom);
    begin
      int m;
      pushGeneration(rand_in, m);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitAccess(1'b0, 1 * GL + 0, found);
    ackHold = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checkReset("async_reset");
    @(negedge clk);
    rst = 1'b0;
    expQ.delete();
    ackHold = 1'b0;
    runGen(24'($urandom), 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
